// File: rtl/data_offload_dst_checker.sv
// data_offload_dst_checker
// AXI-Stream sink for the destination side of a data_offload instance.
// It produces a programmable tready pattern and checks the received words against
// an incrementing pattern. It also checks TLAST placement against a frame length.
// Beat, frame and error counters let a bench or board self-test judge the path.

module data_offload_dst_checker #(
    parameter int DATA_WIDTH = 64,
    parameter int TIME_WIDTH = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cfg_enable,
    input  logic                  cfg_clear,
    input  logic [1:0]            cfg_ready_mode,
    input  logic [TIME_WIDTH-1:0] cfg_high_time,
    input  logic [TIME_WIDTH-1:0] cfg_low_time,
    input  logic [DATA_WIDTH-1:0] cfg_seed,
    input  logic [CNT_WIDTH-1:0]  cfg_frame_length,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_last,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  data_err_count,
    output logic [CNT_WIDTH-1:0]  last_err_count,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ready_state_t;

    localparam logic [TIME_WIDTH-1:0] ONE_T   = TIME_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  ONE_C   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
    localparam logic [DATA_WIDTH-1:0] ONE_D   = DATA_WIDTH'(1);
    localparam logic [15:0]           LFSR_TAPS = 16'hB400;

    ready_state_t          state;
    logic [TIME_WIDTH-1:0] phase_cnt;
    logic [TIME_WIDTH-1:0] high_load;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_next;
    logic                  mode_osc;
    logic                  mode_lfsr;

    logic                  accept;
    logic                  need_seed;
    logic [DATA_WIDTH-1:0] expected_word;
    logic [DATA_WIDTH-1:0] cmp_word;
    logic [CNT_WIDTH-1:0]  beat_index;
    logic                  len_check;
    logic                  frame_end;
    logic                  last_bad;

    assign mode_osc  = (cfg_ready_mode == 2'd1);
    assign mode_lfsr = (cfg_ready_mode == 2'd2);
    assign high_load = (cfg_high_time == '0) ? ONE_T : cfg_high_time;
    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

    assign accept    = s_axis_valid && s_axis_ready;
    assign cmp_word  = need_seed ? cfg_seed : expected_word;
    assign len_check = (cfg_frame_length != '0);
    assign frame_end = len_check && (beat_index == cfg_frame_length - ONE_C);
    assign last_bad  = len_check && (s_axis_last != frame_end);

    // Ready generator: registered tready from the IDLE/HIGH/LOW phase machine or the LFSR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            s_axis_ready <= 1'b0;
            phase_cnt    <= '0;
            lfsr         <= 16'hFFFF;
        end else if (!cfg_enable) begin
            state        <= IDLE;
            s_axis_ready <= 1'b0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                IDLE: begin
                    state        <= HIGH;
                    phase_cnt    <= high_load;
                    s_axis_ready <= mode_lfsr ? lfsr[0] : 1'b1;
                end
                HIGH: begin
                    if (mode_lfsr) begin
                        s_axis_ready <= lfsr[0];
                    end else if (mode_osc) begin
                        if (phase_cnt <= ONE_T) begin
                            if (cfg_low_time != '0) begin
                                state        <= LOW;
                                phase_cnt    <= cfg_low_time;
                                s_axis_ready <= 1'b0;
                            end else begin
                                phase_cnt    <= high_load;
                                s_axis_ready <= 1'b1;
                            end
                        end else begin
                            phase_cnt    <= phase_cnt - ONE_T;
                            s_axis_ready <= 1'b1;
                        end
                    end else begin
                        s_axis_ready <= 1'b1;
                    end
                end
                LOW: begin
                    if (phase_cnt <= ONE_T) begin
                        state        <= HIGH;
                        phase_cnt    <= high_load;
                        s_axis_ready <= mode_lfsr ? lfsr[0] : 1'b1;
                    end else begin
                        phase_cnt    <= phase_cnt - ONE_T;
                        s_axis_ready <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    s_axis_ready <= 1'b0;
                end
            endcase
        end
    end

    // Payload and TLAST checker with saturating statistics; a beat coinciding with clear is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            beat_count     <= '0;
            frame_count    <= '0;
            data_err_count <= '0;
            last_err_count <= '0;
            first_err_data <= '0;
            expected_word  <= '0;
            need_seed      <= 1'b1;
            beat_index     <= '0;
        end else if (cfg_clear) begin
            beat_count     <= '0;
            frame_count    <= '0;
            data_err_count <= '0;
            last_err_count <= '0;
            first_err_data <= '0;
            expected_word  <= cfg_seed;
            need_seed      <= 1'b0;
            beat_index     <= '0;
        end else begin
            need_seed <= 1'b0;
            if (need_seed) begin
                expected_word <= cfg_seed;
            end
            if (accept) begin
                expected_word <= s_axis_data + ONE_D;
                if (beat_count != CNT_MAX) begin
                    beat_count <= beat_count + ONE_C;
                end
                if (s_axis_last && (frame_count != CNT_MAX)) begin
                    frame_count <= frame_count + ONE_C;
                end
                if (s_axis_data != cmp_word) begin
                    if (data_err_count == '0) begin
                        first_err_data <= s_axis_data;
                    end
                    if (data_err_count != CNT_MAX) begin
                        data_err_count <= data_err_count + ONE_C;
                    end
                end
                if (last_bad && (last_err_count != CNT_MAX)) begin
                    last_err_count <= last_err_count + ONE_C;
                end
                beat_index <= (s_axis_last || frame_end) ? '0 : beat_index + ONE_C;
            end
        end
    end

    // Sticky error flag, one cycle behind the error counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (cfg_clear) begin
            err <= 1'b0;
        end else begin
            err <= (data_err_count != '0) || (last_err_count != '0);
        end
    end

endmodule

// File: tb/tb_data_offload_dst_checker.sv
// tb_data_offload_dst_checker
// Randomized and directed stimulus with a scoreboard. The driver runs a behavioural
// model per issued beat and queues the expected statistics. A monitor pops one entry
// per accepted beat and compares it against the counters and the lagged err flag.

module tb_data_offload_dst_checker;

    localparam int DW   = 64;
    localparam int TW   = 16;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cfg_enable;
    logic          cfg_clear;
    logic [1:0]    cfg_ready_mode;
    logic [TW-1:0] cfg_high_time;
    logic [TW-1:0] cfg_low_time;
    logic [DW-1:0] cfg_seed;
    logic [CW-1:0] cfg_frame_length;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_last;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] data_err_count;
    logic [CW-1:0] last_err_count;
    logic [DW-1:0] first_err_data;
    logic          err;

    typedef struct {
        int            beats;
        int            frames;
        int            derr;
        int            lerr;
        logic [DW-1:0] first_err;
    } exp_t;

    exp_t          sbq[$];
    exp_t          cur;
    int            n_checks = 0;
    int            n_fails  = 0;
    bit            mon_on   = 1'b0;
    bit            pend     = 1'b0;
    bit            err_lag_valid = 1'b0;
    bit            err_lag  = 1'b0;

    logic [DW-1:0] m_seed;
    logic [DW-1:0] m_prev;
    logic [DW-1:0] m_first_err;
    bit            m_first;
    int            m_len;
    int            m_idx;
    int            m_beats;
    int            m_frames;
    int            m_derr;
    int            m_lerr;

    data_offload_dst_checker #(
        .DATA_WIDTH(DW),
        .TIME_WIDTH(TW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .cfg_enable      (cfg_enable),
        .cfg_clear       (cfg_clear),
        .cfg_ready_mode  (cfg_ready_mode),
        .cfg_high_time   (cfg_high_time),
        .cfg_low_time    (cfg_low_time),
        .cfg_seed        (cfg_seed),
        .cfg_frame_length(cfg_frame_length),
        .s_axis_valid    (s_axis_valid),
        .s_axis_ready    (s_axis_ready),
        .s_axis_data     (s_axis_data),
        .s_axis_last     (s_axis_last),
        .beat_count      (beat_count),
        .frame_count     (frame_count),
        .data_err_count  (data_err_count),
        .last_err_count  (last_err_count),
        .first_err_data  (first_err_data),
        .err             (err)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s", name);
    endtask

    task automatic modelReset(input logic [DW-1:0] seed, input int len);
        m_seed      = seed;
        m_prev      = '0;
        m_first     = 1'b1;
        m_len       = len;
        m_idx       = 0;
        m_beats     = 0;
        m_frames    = 0;
        m_derr      = 0;
        m_lerr      = 0;
        m_first_err = '0;
    endtask

    function automatic logic [DW-1:0] nextGood();
        logic [DW-1:0] w;
        w = m_prev + 64'd1;
        return m_first ? m_seed : w;
    endfunction

    // Reference: each accepted word should be the seed, or one more than the previous word;
    // a frame should close exactly on its len-th beat when a length is programmed.
    task automatic modelPush(input logic [DW-1:0] d, input logic l);
        exp_t e;
        bit   at_end;
        if (m_beats < CMAX) m_beats++;
        if (l && m_frames < CMAX) m_frames++;
        if (d != nextGood()) begin
            if (m_derr == 0) m_first_err = d;
            if (m_derr < CMAX) m_derr++;
        end
        if (m_len != 0) begin
            at_end = (m_idx == m_len - 1);
            if ((l != at_end) && m_lerr < CMAX) m_lerr++;
            m_idx = (l || at_end) ? 0 : m_idx + 1;
        end else begin
            m_idx = l ? 0 : m_idx + 1;
        end
        m_prev  = d;
        m_first = 1'b0;
        e.beats     = m_beats;
        e.frames    = m_frames;
        e.derr      = m_derr;
        e.lerr      = m_lerr;
        e.first_err = m_first_err;
        sbq.push_back(e);
    endtask

    // Presents one beat and holds it until the handshake; entered and left just after a posedge.
    task automatic applyStimulus(input logic [DW-1:0] d, input logic l);
        int waited = 0;
        modelPush(d, l);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = l;
        forever begin
            @(negedge clk);
            if (s_axis_ready) break;
            waited++;
            if (waited > 300) begin
                reportFail("handshake timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 || pend) begin
            @(posedge clk);
            #2;
            n++;
            if (n > 100) begin
                reportFail("scoreboard drain timeout");
                sbq.delete();
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic setupPhase(input logic [1:0] mode, input int hi, input int lo,
                              input logic [DW-1:0] seed, input int len);
        mon_on           = 1'b0;
        cfg_enable       = 1'b0;
        cfg_ready_mode   = mode;
        cfg_high_time    = TW'(hi);
        cfg_low_time     = TW'(lo);
        cfg_seed         = seed;
        cfg_frame_length = CW'(len);
        @(posedge clk);
        #1;
        cfg_clear = 1'b1;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0;
        modelReset(seed, len);
        mon_on     = 1'b1;
        cfg_enable = 1'b1;
    endtask

    task automatic randomPhase(input logic [1:0] mode, input int hi, input int lo,
                               input logic [DW-1:0] seed, input int len, input int beats,
                               input int err_pct, input bit gaps);
        logic [DW-1:0] d;
        logic          l;
        int            r;
        setupPhase(mode, hi, lo, seed, len);
        for (int n = 0; n < beats; n++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            d = nextGood();
            r = $urandom_range(0, 99);
            if (r < err_pct) begin
                if (r % 2 == 1) d = d + 64'd2;
                else            d = {$urandom, $urandom};
            end
            if (len != 0) l = (m_idx == len - 1) ^ ($urandom_range(0, 9) == 0);
            else          l = ($urandom_range(0, 5) == 0);
            applyStimulus(d, l);
        end
        drain();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " ready"},          {63'd0, s_axis_ready}, '0);
        checkOutput({tag, " beat_count"},     {56'd0, beat_count}, '0);
        checkOutput({tag, " frame_count"},    {56'd0, frame_count}, '0);
        checkOutput({tag, " data_err_count"}, {56'd0, data_err_count}, '0);
        checkOutput({tag, " last_err_count"}, {56'd0, last_err_count}, '0);
        checkOutput({tag, " first_err_data"}, first_err_data, '0);
        checkOutput({tag, " err"},            {63'd0, err}, '0);
    endtask

    // Monitor: checks err against the previous expectation, then pops one entry per accepted beat.
    always @(negedge clk) begin
        if (mon_on) begin
            if (err_lag_valid) checkOutput("err flag", {63'd0, err}, {63'd0, err_lag});
            if (pend) begin
                if (sbq.size() == 0) begin
                    reportFail("scoreboard underflow");
                end else begin
                    cur = sbq.pop_front();
                    checkOutput("beat_count",     {56'd0, beat_count},     64'(cur.beats));
                    checkOutput("frame_count",    {56'd0, frame_count},    64'(cur.frames));
                    checkOutput("data_err_count", {56'd0, data_err_count}, 64'(cur.derr));
                    checkOutput("last_err_count", {56'd0, last_err_count}, 64'(cur.lerr));
                    checkOutput("first_err_data", first_err_data,          cur.first_err);
                end
            end
            err_lag       = (cur.derr != 0) || (cur.lerr != 0);
            err_lag_valid = 1'b1;
            pend          = s_axis_valid && s_axis_ready;
        end else begin
            pend          = 1'b0;
            err_lag_valid = 1'b0;
            cur           = '{0, 0, 0, 0, '0};
        end
    end

    // Main sequence of directed scenarios followed by randomized phases.
    initial begin
        logic [DW-1:0] d;
        int            acc;
        resetn           = 1'b0;
        cfg_enable       = 1'b0;
        cfg_clear        = 1'b0;
        cfg_ready_mode   = 2'd0;
        cfg_high_time    = '0;
        cfg_low_time     = '0;
        cfg_seed         = '0;
        cfg_frame_length = '0;
        s_axis_valid     = 1'b0;
        s_axis_data      = '0;
        s_axis_last      = 1'b0;
        cur              = '{0, 0, 0, 0, '0};
        modelReset('0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] mode 0, seed 0, frame length 16, 64 beats");
        setupPhase(2'd0, 1, 0, '0, 16);
        @(negedge clk);
        checkOutput("ready before enable edge", {63'd0, s_axis_ready}, '0);
        @(negedge clk);
        checkOutput("ready one cycle after enable", {63'd0, s_axis_ready}, 64'd1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) applyStimulus(64'(i), (i % 16) == 15);
        drain();
        checkOutput("mode0 beats",  {56'd0, beat_count},  64'd64);
        checkOutput("mode0 frames", {56'd0, frame_count}, 64'd4);
        checkOutput("mode0 err",    {63'd0, err},         '0);

        $display("[TB] mode 1, high 3, low 2, valid held");
        setupPhase(2'd1, 3, 2, 64'h40, 0);
        fork
            begin
                for (int i = 0; i < 15; i++) applyStimulus(nextGood(), 1'b0);
            end
            begin
                acc = 0;
                @(negedge clk);
                checkOutput("mode1 ready while idle", {63'd0, s_axis_ready}, '0);
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("mode1 ready pattern %0d", i),
                                {63'd0, s_axis_ready}, ((i % 5) < 3) ? 64'd1 : 64'd0);
                    if (i < 5 && s_axis_valid && s_axis_ready) acc++;
                end
                checkOutput("mode1 beats per 5 cycles", 64'(acc), 64'd3);
            end
        join
        drain();

        $display("[TB] dropped word 10 in a 0..31 stream");
        setupPhase(2'd0, 1, 0, '0, 0);
        for (int i = 0; i < 32; i++) if (i != 10) applyStimulus(64'(i), 1'b0);
        drain();
        checkOutput("drop data_err_count", {56'd0, data_err_count}, 64'd1);
        checkOutput("drop first_err_data", first_err_data,          64'd11);
        checkOutput("drop beat_count",     {56'd0, beat_count},     64'd31);
        checkOutput("drop err",            {63'd0, err},            64'd1);

        $display("[TB] frame length 8 with early last");
        setupPhase(2'd0, 1, 0, 64'h500, 8);
        for (int i = 0; i < 16; i++) applyStimulus(64'h500 + 64'(i), (i == 5) || (i == 7) || (i == 15));
        drain();
        checkOutput("early last last_err_count", {56'd0, last_err_count}, 64'd2);
        checkOutput("early last frame_count",    {56'd0, frame_count},    64'd3);

        $display("[TB] clear coinciding with a beat");
        setupPhase(2'd0, 1, 0, 64'h100, 0);
        applyStimulus(64'h100, 1'b0);
        applyStimulus(64'h101, 1'b0);
        drain();
        mon_on       = 1'b0;
        s_axis_valid = 1'b1;
        s_axis_data  = 64'hAA;
        s_axis_last  = 1'b0;
        cfg_clear    = 1'b1;
        @(negedge clk);
        checkOutput("clear beat presented with ready", {63'd0, s_axis_ready}, 64'd1);
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        cfg_clear    = 1'b0;
        @(negedge clk);
        checkOutput("clear beat_count", {56'd0, beat_count}, '0);
        @(posedge clk);
        #1;
        modelReset(64'h100, 0);
        mon_on = 1'b1;
        applyStimulus(64'h100, 1'b0);
        applyStimulus(64'h101, 1'b0);
        drain();
        checkOutput("after clear beat_count",     {56'd0, beat_count},     64'd2);
        checkOutput("after clear data_err_count", {56'd0, data_err_count}, '0);

        $display("[TB] data wrap");
        setupPhase(2'd0, 1, 0, '1, 0);
        d = '1;
        applyStimulus(d, 1'b0);
        applyStimulus('0, 1'b0);
        applyStimulus(64'd1, 1'b0);
        drain();
        checkOutput("wrap data_err_count", {56'd0, data_err_count}, '0);

        $display("[TB] randomized phases");
        randomPhase(2'd0, 1, 0, {$urandom, $urandom}, 5, 60, 15, 1'b1);
        randomPhase(2'd1, $urandom_range(1, 4), $urandom_range(0, 3), {$urandom, $urandom}, 0, 60, 15, 1'b1);
        randomPhase(2'd2, 1, 0, {$urandom, $urandom}, 7, 60, 15, 1'b1);
        randomPhase(2'd3, 2, 2, {$urandom, $urandom}, 3, 40, 15, 1'b0);
        randomPhase(2'd1, 0, 0, {$urandom, $urandom}, 4, 40, 10, 1'b1);

        $display("[TB] counter saturation");
        randomPhase(2'd0, 1, 0, '0, 2, 300, 90, 1'b0);
        checkOutput("saturated beat_count",     {56'd0, beat_count},     64'(CMAX));
        checkOutput("saturated data_err_count", {56'd0, data_err_count}, 64'(CMAX));

        $display("[TB] enable falling mid-frame");
        setupPhase(2'd0, 1, 0, 64'h2000, 8);
        for (int i = 0; i < 3; i++) applyStimulus(nextGood(), 1'b0);
        d = nextGood();
        modelPush(d, 1'b0);
        s_axis_valid = 1'b1;
        s_axis_data  = d;
        s_axis_last  = 1'b0;
        cfg_enable   = 1'b0;
        @(negedge clk);
        checkOutput("ready at enable fall", {63'd0, s_axis_ready}, 64'd1);
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
        @(negedge clk);
        checkOutput("ready after enable fall", {63'd0, s_axis_ready}, '0);
        repeat (3) @(negedge clk);
        checkOutput("held beat_count", {56'd0, beat_count}, 64'd4);
        checkOutput("held ready",      {63'd0, s_axis_ready}, '0);
        drain();

        $display("[TB] reset mid-frame");
        cfg_enable = 1'b1;
        applyStimulus(nextGood(), 1'b0);
        applyStimulus(nextGood(), 1'b0);
        drain();
        mon_on = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        checkAllZero("async reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        modelReset(cfg_seed, int'(cfg_frame_length));
        mon_on = 1'b1;
        applyStimulus(cfg_seed, 1'b0);
        applyStimulus(cfg_seed + 64'd1, 1'b0);
        drain();
        checkOutput("post reset beat_count",     {56'd0, beat_count},     64'd2);
        checkOutput("post reset data_err_count", {56'd0, data_err_count}, '0);

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/data_offload_dst_checker.md
Name: data_offload_dst_checker

Overview:
- Synthesizable AXI-Stream sink that sits on the destination side of a data_offload instance and consumes its output stream.
- Generates a programmable tready pattern: always-ready, fixed high/low duty, or pseudo-random.
- Checks the received payload against an incrementing-word pattern and checks TLAST placement against a programmed frame length.
- Exposes beat, frame and error counters so directed benches and on-board self-test can judge the offload path without a software scoreboard.

Parameters:
- DATA_WIDTH, 64, width of s_axis_data in bits.
- TIME_WIDTH, 16, width of the high/low ready-time fields.
- CNT_WIDTH, 32, width of the beat, frame and error counters.

Ports:
- clk  input  1  single clock for all logic.
- resetn  input  1  asynchronous active-low reset.
- cfg_enable  input  1  sink active; when 0, s_axis_ready is 0.
- cfg_clear  input  1  synchronous pulse; clears counters and re-arms the checker.
- cfg_ready_mode  input  2  0=always, 1=oscillate, 2=LFSR, 3=reserved (behaves as 0).
- cfg_high_time  input  TIME_WIDTH  ready-high cycles in mode 1; 0 is treated as 1.
- cfg_low_time  input  TIME_WIDTH  ready-low cycles in mode 1; 0 means no low phase.
- cfg_seed  input  DATA_WIDTH  expected first word after reset or clear.
- cfg_frame_length  input  CNT_WIDTH  beats per frame; 0 disables the TLAST check.
- s_axis_valid  input  1  AXIS valid.
- s_axis_ready  output  1  AXIS ready.
- s_axis_data  input  DATA_WIDTH  AXIS data.
- s_axis_last  input  1  AXIS last.
- beat_count  output  CNT_WIDTH  accepted beats.
- frame_count  output  CNT_WIDTH  accepted beats with s_axis_last=1.
- data_err_count  output  CNT_WIDTH  data mismatches.
- last_err_count  output  CNT_WIDTH  TLAST placement errors.
- first_err_data  output  DATA_WIDTH  received word of the first data mismatch.
- err  output  1  sticky; set when either error count is non-zero.

Behaviour:
- Reset values (resetn=0, asynchronous): s_axis_ready=0, all counters=0, first_err_data=0, err=0, expected word=0, beat-in-frame index=0, ready FSM=IDLE, LFSR=all-ones.
- Beat acceptance: a beat is accepted when s_axis_valid && s_axis_ready at posedge clk.
- s_axis_ready is registered and never depends combinationally on s_axis_valid.
- Ready FSM states: IDLE, HIGH, LOW.
  - IDLE: s_axis_ready=0. Moves to HIGH on the first cycle cfg_enable=1, loading the high-time counter.
  - HIGH: s_axis_ready=1. Mode 0/3 stays in HIGH indefinitely. Mode 1 counts down max(cfg_high_time,1) cycles, then goes to LOW if cfg_low_time!=0, otherwise reloads HIGH.
  - LOW: s_axis_ready=0. Counts cfg_low_time cycles, then goes to HIGH.
  - Mode 2: 16-bit Galois LFSR with taps x^16+x^14+x^13+x^11+1, advanced every cycle while enabled. s_axis_ready(next) = LFSR bit 0; the FSM remains in HIGH.
- Counter timing: the high/low counters are loaded from cfg_* only on state entry, so mid-phase config changes take effect at the next phase.
- cfg_enable falling: FSM returns to IDLE and s_axis_ready is 0 on the next cycle. A beat presented in the cycle enable falls is still accepted if ready was 1. Counters, expected word and frame index are retained.
- Data check: the expected word is loaded with cfg_seed on reset release and on cfg_clear.
  - Per accepted beat: if s_axis_data != expected, data_err_count increments. On the first mismatch, first_err_data is captured.
  - Either way, expected becomes s_axis_data+1, modulo 2^DATA_WIDTH. One dropped word therefore yields exactly one error (resync).
  - Wrap: all-ones data followed by 0 is correct.
- TLAST check (cfg_frame_length!=0):
  - The beat index counts 0..L-1 within a frame.
  - Error if s_axis_last=1 at index!=L-1, or if s_axis_last=0 at index==L-1. Each error increments last_err_count by at most 1 per beat.
  - The index resets to 0 after any beat with s_axis_last=1 or at index==L-1, whichever comes first.
  - cfg_frame_length=0: no TLAST errors; the index resets only on last.
- beat_count increments on every accepted beat; frame_count increments on accepted beats with last=1.
- Counter saturation: all counters saturate at all-ones and do not wrap.
- err is combinational OR of (data_err_count!=0) and (last_err_count!=0), registered once (1-cycle latency after the counter update).
- cfg_clear:
  - Zeroes counters, first_err_data and err, reloads expected from cfg_seed, and zeroes the frame index.
  - Ready FSM state is unaffected.
  - A beat accepted in the same cycle as cfg_clear is discarded from all statistics; the next beat is checked against cfg_seed.
- Reset mid-frame: everything returns to reset values immediately (asynchronous). Post-reset, the first beat is checked against cfg_seed.

Test Plan:
- Mode 0, seed=0, L=16, 64 incrementing beats with last every 16th → ready high one cycle after enable; beat=64, frame=4, both error counts 0, err=0.
- Mode 1, high=3, low=2, valid held high → ready pattern 1,1,1,0,0 repeating; exactly 3 beats accepted per 5 cycles.
- Drop word 10 in a 0..31 stream, L=0 → data_err_count=1, first_err_data=11, beat=31, err=1 one cycle after the bad beat.
- L=8, last asserted at beat index 5 and again at the next index 7 → last_err_count=2; frame index realigns after the early last.
- cfg_clear with valid beat 0xAA in the same cycle, seed=0x100, next beats 0x100,0x101 → counters 0 then beat=2, no errors.
- Data 0xFFFF_FFFF_FFFF_FFFF followed by 0; separately, drop enable mid-frame, then assert resetn=0 mid-frame → no error on the wrap; after the enable drop, ready=0 next cycle with counts held; after the reset, all outputs are 0 asynchronously.
